// File: rtl/vga_pmod_capture.sv
// vga_pmod_capture: receive-side monitor for the 8-bit TinyVGA PMOD bus.
// Recovers hsync/vsync timing, measures line and frame geometry, locks onto a
// stable mode and reports a per-frame CRC-16-CCITT and lit-pixel count taken
// over a parameterised active window. Runs on the pixel clock.
//
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   pmod_in     {hsync, R1, G1, B1, vsync, R0, G0, B0}
//   h_total     clocks per line, last measured
//   h_sync_w    hsync pulse width in clocks
//   v_total     lines per frame, last measured
//   v_sync_w    vsync pulse width in lines
//   locked      stable mode detected
//   no_signal   hsync absent for 2047 clocks
//   frame_done  one-cycle pulse at each vsync leading edge after a complete frame
//   frame_crc   CRC of the active window of the frame just ended
//   lit_count   nonzero-RGB pixels in the active window of the frame just ended
module vga_pmod_capture #(
    parameter int unsigned H_START         = 144,
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_START         = 35,
    parameter int unsigned V_ACTIVE        = 480,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pmod_in,
    output logic [10:0] h_total,
    output logic [10:0] h_sync_w,
    output logic [9:0]  v_total,
    output logic [9:0]  v_sync_w,
    output logic        locked,
    output logic        no_signal,
    output logic        frame_done,
    output logic [15:0] frame_crc,
    output logic [18:0] lit_count
);

    localparam logic [10:0] HMax   = 11'h7FF;
    localparam logic [9:0]  VMax   = 10'h3FF;
    localparam logic [10:0] HWinLo = 11'(H_START);
    localparam logic [10:0] HWinHi = 11'(H_START + H_ACTIVE - 1);
    localparam logic [9:0]  VWinLo = 10'(V_START);
    localparam logic [9:0]  VWinHi = 10'(V_START + V_ACTIVE - 1);

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} lock_state_e;

    // Bit-serial CRC-16-CCITT (poly 0x1021), d[5] shifted in first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [5:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 5; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [7:0]  s1_q;
    logic [1:0]  s2_sync_q;  // {hsync, vsync} of the previous s1
    logic [10:0] h_cnt_q, h_cnt;
    logic [9:0]  v_cnt_q, v_cnt;
    logic [10:0] h_total_q, h_sync_w_q;
    logic [9:0]  v_total_q, v_sync_w_q;
    logic        no_signal_q, locked_q, frame_done_q, first_frame_q;
    logic [15:0] crc_acc_q, frame_crc_q;
    logic [18:0] lit_acc_q, lit_count_q;
    logic [10:0] ref_h_q, ref_h_d;
    logic [9:0]  ref_v_q, ref_v_d;
    lock_state_e state_q, state_d;

    logic hs_now, hs_prev, vs_now, vs_prev;
    logic hs_lead, hs_trail, vs_lead, vs_trail;
    logic ns_set, frame_evt, active, match;
    logic [5:0] rgb;

    // Normalise so that 1 always means "sync asserted".
    assign hs_now  = s1_q[7] ^ SYNC_ACTIVE_LOW;
    assign vs_now  = s1_q[3] ^ SYNC_ACTIVE_LOW;
    assign hs_prev = s2_sync_q[1] ^ SYNC_ACTIVE_LOW;
    assign vs_prev = s2_sync_q[0] ^ SYNC_ACTIVE_LOW;

    assign hs_lead  = hs_now & ~hs_prev;
    assign hs_trail = ~hs_now & hs_prev;
    assign vs_lead  = vs_now & ~vs_prev;
    assign vs_trail = ~vs_now & vs_prev;

    assign rgb = {s1_q[0], s1_q[4], s1_q[1], s1_q[5], s1_q[2], s1_q[6]};

    // h_cnt/v_cnt are the counts belonging to the sample currently in s1; the
    // registers hold the previous cycle's count.
    always_comb begin
        h_cnt = '0;
        if (!hs_lead) h_cnt = (h_cnt_q == HMax) ? HMax : h_cnt_q + 11'd1;

        v_cnt = v_cnt_q;
        if (vs_lead)                          v_cnt = '0;
        else if (hs_lead && v_cnt_q != VMax)  v_cnt = v_cnt_q + 10'd1;
    end

    assign active = (h_cnt >= HWinLo) && (h_cnt <= HWinHi) &&
                    (v_cnt >= VWinLo) && (v_cnt <= VWinHi);

    // Counter has just saturated with no hsync in sight.
    assign ns_set = !hs_lead && (h_cnt == HMax);

    // A vsync while the signal is lost (or the first one after) only arms.
    assign frame_evt = vs_lead && !first_frame_q && !no_signal_q && !ns_set;

    assign match = (h_total_q == ref_h_q) && (v_cnt_q == ref_v_q);

    always_comb begin
        state_d = state_q;
        ref_h_d = ref_h_q;
        ref_v_d = ref_v_q;
        if (ns_set || no_signal_q) begin
            state_d = StSearch;
        end else if (frame_evt) begin
            unique case (state_q)
                StSearch: begin
                    state_d = StMeasure;
                    ref_h_d = h_total_q;
                    ref_v_d = v_cnt_q;
                end
                StMeasure, StLocked: begin
                    if (match) begin
                        state_d = StLocked;
                    end else begin
                        state_d = StSearch;
                        ref_h_d = h_total_q;
                        ref_v_d = v_cnt_q;
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q          <= '0;
            s2_sync_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_total_q     <= '0;
            h_sync_w_q    <= '0;
            v_total_q     <= '0;
            v_sync_w_q    <= '0;
            no_signal_q   <= 1'b0;
            locked_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            first_frame_q <= 1'b1;
            crc_acc_q     <= 16'hFFFF;
            frame_crc_q   <= '0;
            lit_acc_q     <= '0;
            lit_count_q   <= '0;
            ref_h_q       <= '0;
            ref_v_q       <= '0;
            state_q       <= StSearch;
        end else begin
            s1_q      <= pmod_in;
            s2_sync_q <= {s1_q[7], s1_q[3]};
            h_cnt_q   <= h_cnt;
            v_cnt_q   <= v_cnt;
            state_q   <= state_d;
            ref_h_q   <= ref_h_d;
            ref_v_q   <= ref_v_d;
            locked_q  <= (state_d == StLocked);

            // A saturated count is not a real line length.
            if (hs_lead && h_cnt_q != HMax) h_total_q <= h_cnt_q + 11'd1;
            if (hs_trail) h_sync_w_q <= h_cnt;
            if (vs_trail) v_sync_w_q <= v_cnt;

            if (hs_lead)     no_signal_q <= 1'b0;
            else if (ns_set) no_signal_q <= 1'b1;

            if (ns_set || no_signal_q) first_frame_q <= 1'b1;
            else if (vs_lead)          first_frame_q <= 1'b0;

            frame_done_q <= frame_evt;
            if (frame_evt) begin
                v_total_q   <= v_cnt_q;
                frame_crc_q <= crc_acc_q;
                lit_count_q <= lit_acc_q;
            end

            if (vs_lead) begin
                crc_acc_q <= 16'hFFFF;
                lit_acc_q <= '0;
            end else if (active) begin
                crc_acc_q <= crc_step(crc_acc_q, rgb);
                if (rgb != 6'd0) lit_acc_q <= lit_acc_q + 19'd1;
            end
        end
    end

    assign h_total    = h_total_q;
    assign h_sync_w   = h_sync_w_q;
    assign v_total    = v_total_q;
    assign v_sync_w   = v_sync_w_q;
    assign locked     = locked_q;
    assign no_signal  = no_signal_q;
    assign frame_done = frame_done_q;
    assign frame_crc  = frame_crc_q;
    assign lit_count  = lit_count_q;

endmodule

// File: tb/tb_vga_pmod_capture.sv
// Bench for vga_pmod_capture. Uses a scaled-down mode (32 clocks x 14 lines,
// 16x8 active) so that many frames fit in a short run; the window parameters
// are derived from that mode exactly as 144/35 derive from 800x525.
module tb_vga_pmod_capture;

    localparam int HT  = 32;  // clocks per line
    localparam int HA  = 16;  // active pixels
    localparam int HS  = 20;  // hsync start position
    localparam int HW  = 4;   // hsync width
    localparam int VA  = 8;   // active lines
    localparam int VSO = 4;   // vsync starts at line vt-VSO
    localparam int VW  = 2;   // vsync width in lines

    typedef struct {
        int vt;          // lines in this frame
        int mode;        // 0 black, 1 single 0x3F pixel, 2 only pmod_in[0] in window
        int px;
        int py;
        int rst_line;    // line where rst_n pulses low, -1 for none
        bit idle;        // drop all sync for 3000 clocks before the frame
        bit exp_fd;
        int exp_locked;  // 0/1, 2 = not checked
        int exp_lit;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pmod_in;
    logic [10:0] h_total, h_sync_w;
    logic [9:0]  v_total, v_sync_w;
    logic        locked, no_signal, frame_done;
    logic [15:0] frame_crc;
    logic [18:0] lit_count;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_seen = 0;
    int fd_exp  = 0;
    int chk_cnt = 0;
    vec_t        cur;
    logic [15:0] cur_crc;
    vec_t        vecs[15];

    vga_pmod_capture #(
        .H_START        (HT - HS),
        .H_ACTIVE       (HA),
        .V_START        (VSO),
        .V_ACTIVE       (VA),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pmod_in   (pmod_in),
        .h_total   (h_total),
        .h_sync_w  (h_sync_w),
        .v_total   (v_total),
        .v_sync_w  (v_sync_w),
        .locked    (locked),
        .no_signal (no_signal),
        .frame_done(frame_done),
        .frame_crc (frame_crc),
        .lit_count (lit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int vt, int mode, int px, int py, int rst_line, bit idle,
                                bit fd, int lk, int lit);
        vec_t r;
        r.vt = vt; r.mode = mode; r.px = px; r.py = py; r.rst_line = rst_line;
        r.idle = idle; r.exp_fd = fd; r.exp_locked = lk; r.exp_lit = lit;
        return r;
    endfunction

    // Pin value driven at (line, h); syncs are active-low.
    function automatic logic [7:0] pin_val(vec_t r, int line, int h);
        logic       hs, vs;
        logic [7:0] col;
        hs  = (h >= HS) && (h < HS + HW);
        vs  = (line >= r.vt - VSO) && (line < r.vt - VSO + VW);
        col = 8'h00;
        if (r.mode == 1 && h == r.px && line == r.py) col = 8'h77;
        if (r.mode == 2 && h < HA && line < VA)       col = 8'h01;
        return {~hs, 3'b000, ~vs, 3'b000} | col;
    endfunction

    function automatic logic [5:0] rgb_of(logic [7:0] p);
        return {p[0], p[4], p[1], p[5], p[2], p[6]};
    endfunction

    // Golden CRC-16-CCITT over the window, MSB of RGB first.
    function automatic logic [15:0] crc_model(vec_t r);
        logic [15:0] c;
        logic [5:0]  d;
        logic        fb;
        c = 16'hFFFF;
        for (int line = 0; line < VA; line++) begin
            for (int h = 0; h < HA; h++) begin
                d = rgb_of(pin_val(r, line, h));
                for (int b = 5; b >= 0; b--) begin
                    fb = c[15] ^ d[b];
                    c  = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h1021;
                end
            end
        end
        return c;
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, " h_total"},    32'(h_total),    32'd0);
        check({tag, " h_sync_w"},   32'(h_sync_w),   32'd0);
        check({tag, " v_total"},    32'(v_total),    32'd0);
        check({tag, " v_sync_w"},   32'(v_sync_w),   32'd0);
        check({tag, " locked"},     32'(locked),     32'd0);
        check({tag, " no_signal"},  32'(no_signal),  32'd0);
        check({tag, " frame_done"}, 32'(frame_done), 32'd0);
        check({tag, " frame_crc"},  32'(frame_crc),  32'd0);
        check({tag, " lit_count"},  32'(lit_count),  32'd0);
    endtask

    // Runs two clocks after the vsync leading edge reaches the pin.
    task automatic check_frame();
        if (cur.exp_fd) fd_exp++;
        check("frame_done pulse", 32'(frame_done), 32'(cur.exp_fd));
        check("frame_done count", 32'(fd_seen),    32'(fd_exp));
        check("no_signal idle",   32'(no_signal),  32'd0);
        if (cur.exp_fd) begin
            check("h_total",   32'(h_total),   32'(HT));
            check("h_sync_w",  32'(h_sync_w),  32'(HW));
            check("v_total",   32'(v_total),   32'(cur.vt));
            check("v_sync_w",  32'(v_sync_w),  32'(VW));
            check("lit_count", 32'(lit_count), 32'(cur.exp_lit));
            check("frame_crc", 32'(frame_crc), 32'(cur_crc));
            if (cur.exp_locked != 2) check("locked", 32'(locked), 32'(cur.exp_locked));
        end
    endtask

    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        if (frame_done === 1'b1) fd_seen++;
        if (chk_cnt > 0) begin
            chk_cnt--;
            if (chk_cnt == 0) check_frame();
        end
        pmod_in = v;
    endtask

    task automatic run_frame(input vec_t r);
        cur     = r;
        cur_crc = crc_model(r);
        if (r.idle) begin
            for (int i = 0; i < 3000; i++) begin
                drive(8'h88);
                if (i == 2000) check("no_signal before saturation", 32'(no_signal), 32'd0);
                if (i == 2100) check("no_signal after saturation", 32'(no_signal), 32'd1);
            end
            check("locked during no_signal", 32'(locked), 32'd0);
            check("no frame_done while idle", 32'(fd_seen), 32'(fd_exp));
        end
        for (int line = 0; line < r.vt; line++) begin
            for (int h = 0; h < HT; h++) begin
                drive(pin_val(r, line, h));
                if (line == r.vt - VSO && h == 0) chk_cnt = 2;
                if (line == r.rst_line && h == 0) begin
                    rst_n = 1'b0;
                    #1;
                    reset_checks("midframe reset");
                end
                if (line == r.rst_line && h == 2) rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        //             vt  md px py rst idle fd lk lit
        vecs[0]  = mk(14, 0, 0,  0, -1, 0, 0, 0, 0);    // arm after reset
        vecs[1]  = mk(14, 0, 0,  0, -1, 0, 1, 0, 0);    // SEARCH -> MEASURE
        vecs[2]  = mk(14, 0, 0,  0, -1, 0, 1, 2, 0);
        vecs[3]  = mk(14, 1, 0,  0, -1, 0, 1, 1, 1);    // 3rd frame_done, pixel (0,0)
        vecs[4]  = mk(15, 0, 0,  0, -1, 0, 1, 0, 0);    // stretched frame drops lock
        vecs[5]  = mk(14, 1, 16, 0, -1, 0, 1, 0, 0);    // pixel just right of window
        vecs[6]  = mk(14, 2, 0,  0, -1, 0, 1, 1, HA * VA); // relock, pin mapping
        vecs[7]  = mk(14, 1, 15, 7, -1, 0, 1, 1, 1);    // last window pixel
        vecs[8]  = mk(14, 1, 0,  8, -1, 0, 1, 1, 0);    // first line below window
        vecs[9]  = mk(14, 0, 0,  0, -1, 1, 0, 0, 0);    // signal loss, then arm only
        vecs[10] = mk(14, 0, 0,  0, -1, 0, 1, 0, 0);
        vecs[11] = mk(14, 1, 3,  2, -1, 0, 1, 1, 1);
        vecs[12] = mk(14, 0, 0,  0,  5, 0, 0, 0, 0);    // mid-frame reset, arm only
        vecs[13] = mk(14, 0, 0,  0, -1, 0, 1, 0, 0);
        vecs[14] = mk(14, 2, 0,  0, -1, 0, 1, 1, HA * VA);

        rst_n   = 1'b0;
        pmod_in = 8'h88;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 15; k++) run_frame(vecs[k]);
        repeat (4) drive(8'h88);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pmod_capture.md
Name: vga_pmod_capture

Overview:
- Receive-side counterpart of the glyph-mode VGA generator; consumes the 8-bit TinyVGA PMOD bus the generator drives.
- Recovers sync timing, measures line/frame geometry and locks onto a stable mode.
- Produces a per-frame CRC and lit-pixel count over a parameterised active window, for on-chip self-check and bench/FPGA regression of the generators.
- Runs on the pixel clock.

Parameters:
- H_START, 144, clocks after registered hsync leading edge to first active pixel sample
- H_ACTIVE, 640, active pixels per line
- V_START, 35, hsync leading edges after vsync leading edge to first active line
- V_ACTIVE, 480, active lines per frame
- SYNC_ACTIVE_LOW, 1, 1: hsync/vsync asserted when 0; 0: asserted when 1

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset
- pmod_in  in  8  {hsync, R1, G1, B1, vsync, R0, G0, B0}; internal RGB[5:0] = {pmod_in[0], pmod_in[4], pmod_in[1], pmod_in[5], pmod_in[2], pmod_in[6]}
- h_total  out  11  clocks per line, last measured
- h_sync_w  out  11  hsync pulse width in clocks
- v_total  out  10  lines per frame, last measured
- v_sync_w  out  10  vsync pulse width in lines
- locked  out  1  stable mode detected
- no_signal  out  1  hsync absent for 2047 clocks
- frame_done  out  1  one-cycle pulse at each vsync leading edge after a complete frame
- frame_crc  out  16  CRC of active window of the frame just ended
- lit_count  out  19  nonzero-RGB pixels in the active window of the frame just ended

Behaviour:
- Reset: asynchronous, active-low on rst_n. All outputs 0; internal counters 0; first_frame flag set; CRC accumulator 0xFFFF.
- Input stage: pmod_in registered once (s1) plus a previous copy (s2). Edges are detected on s1 vs s2, polarity-normalised by SYNC_ACTIVE_LOW.
- h_cnt (11b):
  - 0 on the hsync leading-edge cycle, else +1.
  - Saturates at 2047; saturation sets no_signal=1 and locked=0.
  - no_signal clears on the next hsync leading edge.
- At hsync leading edge: h_total <= h_cnt+1, except when h_cnt is saturated (no update).
- At hsync trailing edge: h_sync_w <= h_cnt.
- v_cnt (10b):
  - 0 on the vsync leading edge; +1 on each hsync leading edge; saturates at 1023.
  - Vsync and hsync leading edges in the same cycle: v_cnt <= 0 (vsync wins).
- At vsync trailing edge: v_sync_w <= v_cnt.
- Active sample: v_cnt in [V_START, V_START+V_ACTIVE-1] and h_cnt in [H_START, H_START+H_ACTIVE-1].
- On each active sample:
  - CRC-16-CCITT (poly 0x1021), 6 bits per clock, RGB[5] first; unrolled combinational update.
  - lit accumulator +1 if RGB != 0.
- At vsync leading edge:
  - If first_frame=0: v_total <= v_cnt; frame_crc <= accumulator; lit_count <= lit accumulator; frame_done=1 for 1 cycle.
  - Always: CRC accumulator reset to 0xFFFF, lit accumulator to 0, first_frame cleared.
  - The first vsync after reset or after no_signal only arms; no frame_done.
- Lock FSM, states SEARCH, MEASURE, LOCKED, evaluated only at frame_done:
  - SEARCH -> MEASURE: store ref_h = h_total, ref_v = new v_total.
  - MEASURE -> LOCKED: match (h_total == ref_h and v_total == ref_v).
  - MEASURE -> SEARCH: mismatch; refs re-stored.
  - LOCKED -> SEARCH: mismatch; refs re-stored.
  - Any state -> SEARCH on no_signal.
  - locked = 1 only in LOCKED.
  - locked and the new frame_crc/lit_count become visible in the same cycle as frame_done.
- Latency: pin change to s1 = 1 clk; frame_done is 2 clks after the vsync leading edge at the pin.
- Mid-frame rst_n: immediate clear; the next frame is arm-only.

Test Plan:
- Standard 640x480 stimulus (800x525, hsync 96 clks at hpos 656, vsync lines 490-491, all pixels 0) -> h_total=800, h_sync_w=96, v_total=525, v_sync_w=2; locked=1 at the 3rd frame_done after reset; lit_count=0.
- Same timing, RGB=6'h3F only at pixel (0,0) -> lit_count=1; frame_crc equals the golden-model CRC. Pixel moved to (640,0), outside the window -> lit_count=0.
- Swap pin mapping check: drive only pmod_in[0] high in window -> RGB=6'h20; all 307200 active pixels counted (lit_count=307200).
- Frame 4 stretched to 526 lines -> locked drops at that frame_done; relocks 2 frame_dones later.
- Hold hsync inactive for 3000 clks -> no_signal=1 at h_cnt=2047, locked=0, no frame_done; restored timing relocks.
- Assert rst_n low mid-frame (line 200) -> outputs 0 immediately; first vsync after release gives no frame_done.
